router_out_reader: RTL and testbench
====================================

# router_out_reader

Drain-side controller for one output port of the 1x3 router. It pops 9-bit words (header flag + byte) from the port FIFO and accounts for the FIFO's 1-cycle registered read latency. It delivers bytes to the destination over a valid/ready handshake, tracks packet boundaries, and checks the trailing parity byte. It also issues the FIFO soft reset when the destination stops reading for too long.

## Interface
- TIMEOUT, 30, consecutive stalled cycles (vld_out=1, read_enb=0) before flush; legal range 2..255
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- fifo_empty  in  1  port FIFO empty
- fifo_dout  in  9  FIFO read word; bit 8 = header flag, [7:0] = byte; valid the cycle after fifo_rd_en
- fifo_rd_en  out  1  FIFO pop request (combinational)
- fifo_soft_reset  out  1  one-cycle FIFO flush (registered)
- data_out  out  8  byte to destination
- vld_out  out  1  data_out valid
- read_enb  in  1  destination ready; transfer when vld_out & read_enb
- pkt_done  out  1  one-cycle pulse, packet closed
- pkt_err  out  1  one-cycle pulse, coincident with pkt_done or a stray byte
- timeout  out  1  one-cycle pulse, coincident with fifo_soft_reset

## Operation
- Packet format: header {len[5:0], addr[1:0]} with flag=1, then len payload bytes, then 1 parity byte. Parity = XOR of header and all payload bytes.
- 2-entry output buffer; data_out/vld_out are the buffer head.
- inflight flag: set the cycle after fifo_rd_en, when fifo_dout is written into the buffer tail.
- fifo_rd_en = !fifo_empty & !fifo_soft_reset & (occ + inflight - pop) < 2, where pop = vld_out & read_enb. Sustains 1 byte/cycle.
- FSM is advanced by transferred bytes (pop), not by FIFO reads:
  - IDLE: a header-flagged byte loads rem = len+1 (7 bits), acc = byte, then -> BODY.
  - IDLE: a non-header byte is still forwarded; pkt_err pulses and the FSM stays in IDLE.
  - BODY: each byte does acc ^= byte and rem -= 1.
  - BODY, rem==1: the byte is parity. pkt_done pulses; pkt_err = (acc != byte); -> IDLE.
  - BODY, header-flagged byte: truncated packet. pkt_done=1 and pkt_err=1 pulse; the new header is loaded as in IDLE.
- len=0: header then parity byte only; the parity byte must equal the header.
- Stall counter: increments while vld_out & !read_enb and clears on any other cycle. When it reaches TIMEOUT:
  - next cycle: fifo_soft_reset=1, timeout=1
  - same edge: buffer cleared (occ=0), inflight and the word it would deliver dropped, FSM -> IDLE, acc/rem cleared, counter cleared
  - no pkt_done is generated

## Timing
- Reset values: fifo_rd_en=0 (forced), fifo_soft_reset=0, data_out=8'h00, vld_out=0, pkt_done=0, pkt_err=0, timeout=0; FSM IDLE, occ=0, inflight=0, counter=0.
- Reset mid-packet: all state returns to reset values on the next edge, and buffered bytes are lost. Reset has priority over every other event.
- Latency: fifo_rd_en at edge t -> vld_out=1 with that byte after edge t+1 (buffer empty case).
- pkt_done/pkt_err are asserted in the cycle after the edge at which the parity-byte handshake occurs.
- Simultaneous push and pop with occ=2: allowed. The pop is applied first, so occ stays 2.
- vld_out and data_out must hold stable while read_enb=0.
- fifo_rd_en is never asserted while fifo_empty=1.

## Test plan
- Header 0x09 (len 2, flag), 0xA5, 0x3C, parity 0x90, read_enb=1 throughout -> data_out 09,A5,3C,90 on 4 consecutive cycles; pkt_done=1, pkt_err=0 once.
- Same packet with parity 0x91 -> pkt_done=1 and pkt_err=1 on the same cycle.
- Three back-to-back 20-byte packets, read_enb randomly toggled -> no byte lost or duplicated; order preserved; fifo_rd_en never asserted with fifo_empty=1; occ never exceeds 2.
- vld_out=1, read_enb=0 for 30 cycles -> fifo_soft_reset and timeout pulse on cycle 31; vld_out=0 next; FSM IDLE.
- Header 0x11 (len 4), 2 payload bytes, then new header 0x05 -> truncation pulse (done=1, err=1) on the 0x05 transfer; the following packet checks clean.
- reset asserted during BODY with occ=2 -> all outputs zero next cycle; the next packet is processed normally.

Source files
------------

// File: rtl/router_out_reader.sv
// router_out_reader: drains one router port FIFO through a 2-entry buffer to a valid/ready sink,
// checking packet framing and parity, and flushing the FIFO when the sink stalls too long.
module router_out_reader #(
   parameter int TIMEOUT = 30
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       fifo_empty,
   input  logic [8:0] fifo_dout,
   output logic       fifo_rd_en,
   output logic       fifo_soft_reset,
   output logic [7:0] data_out,
   output logic       vld_out,
   input  logic       read_enb,
   output logic       pkt_done,
   output logic       pkt_err,
   output logic       timeout
);
   typedef enum logic {IDLE, BODY} state_t;
   state_t     state, state_n;
   logic [8:0] ob0, ob1;
   logic [1:0] occ;
   logic       inflight, pop, stall, flush, wi, hdr;
   logic [2:0] lvl;
   logic [7:0] stall_cnt, acc, acc_n, head;
   logic [6:0] rem, rem_n;
   logic       done_n, err_n;

   assign vld_out    = occ != 2'd0;
   assign data_out   = ob0[7:0];
   assign head       = ob0[7:0];
   assign hdr        = ob0[8];
   assign pop        = vld_out & read_enb;
   assign stall      = vld_out & !read_enb;
   assign flush      = stall && stall_cnt == 8'(TIMEOUT - 1);
   assign lvl        = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
   assign fifo_rd_en = !reset & !fifo_empty & !fifo_soft_reset & (lvl < 3'd2);
   assign timeout    = fifo_soft_reset;
   // slot the arriving word lands in, after this cycle's pop has shifted the buffer
   assign wi         = occ[1] | (occ[0] & !pop);

   always_ff @(posedge clk) begin
      if (reset) begin
         occ             <= 2'd0;
         inflight        <= 1'b0;
         stall_cnt       <= 8'd0;
         fifo_soft_reset <= 1'b0;
         ob0             <= 9'd0;
         ob1             <= 9'd0;
      end else begin
         fifo_soft_reset <= flush;
         stall_cnt       <= (stall && !flush) ? stall_cnt + 8'd1 : 8'd0;
         if (flush) begin
            occ      <= 2'd0;
            inflight <= 1'b0;
         end else begin
            occ      <= occ + {1'b0, inflight} - {1'b0, pop};
            inflight <= fifo_rd_en;
            if (inflight && !wi) ob0 <= fifo_dout;
            else if (pop) ob0 <= ob1;
            if (inflight && wi) ob1 <= fifo_dout;
         end
      end
   end

   always_comb begin
      state_n = state;
      rem_n   = rem;
      acc_n   = acc;
      done_n  = 1'b0;
      err_n   = 1'b0;
      if (pop) begin
         if (hdr) begin
            state_n = BODY;
            rem_n   = {1'b0, head[7:2]} + 7'd1;
            acc_n   = head;
            done_n  = state == BODY;
            err_n   = state == BODY;
         end else if (state == IDLE) begin
            err_n = 1'b1;
         end else if (rem == 7'd1) begin
            state_n = IDLE;
            rem_n   = 7'd0;
            acc_n   = 8'd0;
            done_n  = 1'b1;
            err_n   = acc != head;
         end else begin
            acc_n = acc ^ head;
            rem_n = rem - 7'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         state    <= IDLE;
         rem      <= 7'd0;
         acc      <= 8'd0;
         pkt_done <= 1'b0;
         pkt_err  <= 1'b0;
      end else begin
         state    <= state_n;
         rem      <= rem_n;
         acc      <= acc_n;
         pkt_done <= done_n;
         pkt_err  <= err_n;
      end
   end
endmodule

// File: tb/tb_router_out_reader.sv
// tb_router_out_reader: directed bench with a registered-read FIFO model and a byte/event scoreboard.
module tb_router_out_reader;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       fifo_empty = 1'b1;
   logic [8:0] fifo_dout = 9'd0;
   logic       fifo_rd_en, fifo_soft_reset, vld_out, pkt_done, pkt_err, timeout;
   logic [7:0] data_out;
   logic       read_enb = 1'b0;

   typedef struct {
      logic [7:0] b;
      logic       d;
      logic       e;
   } exp_t;

   exp_t       sb[$];
   logic [8:0] fq[$];
   int         checks = 0;
   int         errors = 0;
   logic       pv = 1'b0, pd = 1'b0, pe = 1'b0, pst = 1'b0, prst = 1'b1;
   logic [7:0] pdata = 8'd0;

   router_out_reader #(.TIMEOUT(30)) dut (
      .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
      .fifo_rd_en(fifo_rd_en), .fifo_soft_reset(fifo_soft_reset), .data_out(data_out),
      .vld_out(vld_out), .read_enb(read_enb), .pkt_done(pkt_done), .pkt_err(pkt_err),
      .timeout(timeout)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b, input logic h, input logic d, input logic e);
      fq.push_back({h, b});
      sb.push_back('{b: b, d: d, e: e});
   endtask

   task automatic pkt(input logic [5:0] len, input logic bad);
      logic [7:0] h, p, b;
      h = {len, 2'b01};
      p = h;
      send(h, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < int'(len); i++) begin
         b = 8'($urandom);
         p ^= b;
         send(b, 1'b0, 1'b0, 1'b0);
      end
      send(bad ? p ^ 8'h01 : p, 1'b0, 1'b1, bad);
   endtask

   task automatic drain(input logic rnd);
      int n;
      n = 0;
      while (sb.size() != 0 && n < 600) begin
         step(1);
         if (rnd) read_enb = 1'($urandom_range(0, 1));
         n++;
      end
      read_enb = 1'b1;
      step(3);
      check("drain_empty", 9'(sb.size()), 9'd0);
   endtask

   // FIFO model: one-cycle registered read, flushed by soft reset
   always @(posedge clk) begin
      if (fifo_rd_en) begin
         check("rd_while_empty", 9'(fq.size() != 0), 9'd1);
         if (fq.size() != 0) fifo_dout <= fq.pop_front();
      end
      if (fifo_soft_reset) fq.delete();
   end

   always @(negedge clk) fifo_empty <= (fq.size() == 0);

   // scoreboard: byte order plus the done/err pulse owed for the previous transfer
   always @(negedge clk) begin
      exp_t e;
      check("pkt_done", 9'(pkt_done), 9'(pv & pd));
      check("pkt_err", 9'(pkt_err), 9'(pv & pe));
      if (pst && !fifo_soft_reset && !prst) begin
         check("hold_vld", 9'(vld_out), 9'd1);
         check("hold_data", 9'(data_out), 9'(pdata));
      end
      pv = 1'b0;
      if (vld_out && read_enb && !reset) begin
         check("sb_has_entry", 9'(sb.size() != 0), 9'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("data_out", 9'(data_out), 9'(e.b));
            pv = 1'b1;
            pd = e.d;
            pe = e.e;
         end
      end
      pst   = vld_out & !read_enb;
      pdata = data_out;
      prst  = reset;
   end

   initial begin
      int n;
      logic [7:0] x;
      logic [7:0] t1[4];
      t1[0] = 8'h09; t1[1] = 8'hA5; t1[2] = 8'h3C; t1[3] = 8'h90;
      // reset holds fifo_rd_en low even with data waiting
      step(1);
      fq.push_back(9'h1AA);
      step(1);
      check("rst_rd_en", 9'(fifo_rd_en), 9'd0);
      check("rst_vld", 9'(vld_out), 9'd0);
      check("rst_data", 9'(data_out), 9'h00);
      check("rst_soft", 9'(fifo_soft_reset), 9'd0);
      check("rst_timeout", 9'(timeout), 9'd0);
      fq.delete();
      step(1);
      reset = 1'b0;
      read_enb = 1'b1;
      step(2);
      // good packet, 4 consecutive bytes
      send(8'h09, 1'b1, 1'b0, 1'b0);
      send(8'hA5, 1'b0, 1'b0, 1'b0);
      send(8'h3C, 1'b0, 1'b0, 1'b0);
      send(8'h90, 1'b0, 1'b1, 1'b0);
      n = 0;
      @(negedge clk);
      while (!vld_out && n < 10) begin
         @(negedge clk);
         n++;
      end
      for (int k = 0; k < 4; k++) begin
         check("t1_vld", 9'(vld_out), 9'd1);
         check("t1_byte", 9'(data_out), 9'(t1[k]));
         @(negedge clk);
      end
      drain(1'b0);
      // bad parity
      send(8'h09, 1'b1, 1'b0, 1'b0);
      send(8'hA5, 1'b0, 1'b0, 1'b0);
      send(8'h3C, 1'b0, 1'b0, 1'b0);
      send(8'h91, 1'b0, 1'b1, 1'b1);
      drain(1'b0);
      // len 0, good and bad; stray non-header byte in IDLE
      pkt(6'd0, 1'b0);
      pkt(6'd0, 1'b1);
      send(8'h77, 1'b0, 1'b0, 1'b1);
      pkt(6'd3, 1'b0);
      drain(1'b0);
      // truncated packet followed by a clean one
      x = 8'($urandom);
      send(8'h11, 1'b1, 1'b0, 1'b0);
      send(8'h12, 1'b0, 1'b0, 1'b0);
      send(8'h34, 1'b0, 1'b0, 1'b0);
      send(8'h05, 1'b1, 1'b1, 1'b1);
      send(x, 1'b0, 1'b0, 1'b0);
      send(8'h05 ^ x, 1'b0, 1'b1, 1'b0);
      pkt(6'd2, 1'b0);
      drain(1'b0);
      // back-to-back 20-byte packets under random backpressure
      pkt(6'd18, 1'b0);
      pkt(6'd18, 1'b0);
      pkt(6'd18, 1'b1);
      drain(1'b1);
      // stall timeout mid-packet
      send(8'h0D, 1'b1, 1'b0, 1'b0);
      n = 0;
      while (sb.size() != 0 && n < 20) begin
         step(1);
         n++;
      end
      read_enb = 1'b0;
      for (int i = 0; i < 3; i++) send(8'(i + 1), 1'b0, 1'b0, 1'b0);
      n = 0;
      @(negedge clk);
      while (!vld_out && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("to_vld_seen", 9'(vld_out), 9'd1);
      for (int i = 2; i <= 30; i++) begin
         @(negedge clk);
         check("to_no_flush", 9'(fifo_soft_reset), 9'd0);
         check("to_vld_hold", 9'(vld_out), 9'd1);
      end
      @(negedge clk);
      check("to_soft", 9'(fifo_soft_reset), 9'd1);
      check("to_timeout", 9'(timeout), 9'd1);
      check("to_vld_clr", 9'(vld_out), 9'd0);
      sb.delete();
      @(negedge clk);
      check("to_soft_pulse", 9'(fifo_soft_reset), 9'd0);
      check("to_timeout_pulse", 9'(timeout), 9'd0);
      check("to_vld_after", 9'(vld_out), 9'd0);
      step(1);
      read_enb = 1'b1;
      pkt(6'd2, 1'b0);
      drain(1'b0);
      // reset in BODY with a full buffer
      send(8'h29, 1'b1, 1'b0, 1'b0);
      n = 0;
      while (sb.size() != 0 && n < 20) begin
         step(1);
         n++;
      end
      read_enb = 1'b0;
      for (int i = 0; i < 5; i++) send(8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
      step(5);
      check("mid_vld_full", 9'(vld_out), 9'd1);
      reset = 1'b1;
      fq.delete();
      sb.delete();
      #1;
      check("mid_rd_en", 9'(fifo_rd_en), 9'd0);
      step(1);
      reset = 1'b0;
      check("mid_vld", 9'(vld_out), 9'd0);
      check("mid_data", 9'(data_out), 9'h00);
      check("mid_done", 9'(pkt_done), 9'd0);
      check("mid_err", 9'(pkt_err), 9'd0);
      check("mid_soft", 9'(fifo_soft_reset), 9'd0);
      read_enb = 1'b1;
      step(1);
      pkt(6'd5, 1'b0);
      drain(1'b0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
